// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate self-test sequencer: FSM encoding and
// reference truth tables indexed by {a,b}.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } seq_state_t;

    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;

    function automatic logic tt_bit(input logic [3:0] tt, input logic [1:0] vec);
        return tt[vec];
    endfunction

endpackage

// File: rtl/gate_selftest_seq_if.sv
// Controller-side and gate-side signals of the self-test sequencer.
// master = test controller/bench (also returns gate_y), slave = sequencer.
interface gate_selftest_seq_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             clr_err;
    logic [3:0]       expect_tt;
    logic             gate_y;
    logic             gate_a;
    logic             gate_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [3:0]       fail_mask;
    logic [CNT_W-1:0] err_count;

    modport master (
        output start, abort, clr_err, expect_tt, gate_y,
        input  gate_a, gate_b, busy, done, pass, fail_mask, err_count
    );

    modport slave (
        input  start, abort, clr_err, expect_tt, gate_y,
        output gate_a, gate_b, busy, done, pass, fail_mask, err_count
    );
endinterface

// File: rtl/nand_gate_xor.sv
// XOR built from four 2-input NAND gates (converted-gate library style).
module nand_gate_xor (
    input  logic a,
    input  logic b,
    output logic y
);
    logic w_n1;
    logic w_n2;
    logic w_n3;

    assign w_n1 = ~(a & b);
    assign w_n2 = ~(a & w_n1);
    assign w_n3 = ~(b & w_n1);
    assign y    = ~(w_n2 & w_n3);
endmodule

// File: rtl/gate_selftest_seq.sv
// Exhaustive 2-input gate self-test: sweeps {a,b} = 00..11, samples gate_y
// after a programmable settle time and reports pass, fail mask and error count.
module gate_selftest_seq
    import gate_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    gate_selftest_seq_if.slave  bus
);
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    seq_state_t       r_state;
    logic [1:0]       r_vec;
    logic [3:0]       r_cnt;
    logic [3:0]       r_tt;
    logic             r_gate_a;
    logic             r_gate_b;
    logic             r_done;
    logic             r_pass;
    logic [3:0]       r_fail_mask;
    logic [CNT_W-1:0] r_err;

    logic             w_mismatch;
    logic             w_err_inc;
    logic [1:0]       w_vec_next;

    assign w_mismatch = (bus.gate_y != tt_bit(r_tt, r_vec));
    assign w_err_inc  = (r_state == ST_SAMPLE) && !bus.abort && w_mismatch;
    assign w_vec_next = r_vec + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_vec       <= '0;
            r_cnt       <= '0;
            r_tt        <= '0;
            r_gate_a    <= 1'b0;
            r_gate_b    <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state != ST_IDLE && bus.abort) begin
                // Abort leaves fail_mask partial and pass at its start-cleared 0.
                r_state  <= ST_IDLE;
                r_gate_a <= 1'b0;
                r_gate_b <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_gate_a <= 1'b0;
                        r_gate_b <= 1'b0;
                        if (bus.start && !bus.abort) begin
                            r_tt        <= bus.expect_tt;
                            r_vec       <= '0;
                            r_fail_mask <= '0;
                            r_pass      <= 1'b0;
                            r_cnt       <= CNT_LOAD;
                            r_state     <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (r_cnt == '0) r_state <= ST_SAMPLE;
                        else             r_cnt   <= r_cnt - 4'd1;
                    end
                    ST_SAMPLE: begin
                        if (w_mismatch) r_fail_mask[r_vec] <= 1'b1;
                        if (r_vec == 2'd3) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_vec    <= w_vec_next;
                            r_gate_a <= w_vec_next[1];
                            r_gate_b <= w_vec_next[0];
                            r_cnt    <= CNT_LOAD;
                            r_state  <= ST_SETTLE;
                        end
                    end
                    ST_DONE: begin
                        r_done   <= 1'b1;
                        r_pass   <= (r_fail_mask == '0);
                        r_gate_a <= 1'b0;
                        r_gate_b <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Cumulative across sweeps; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else if (bus.clr_err) begin
            r_err <= '0;
        end else if (w_err_inc && !(&r_err)) begin
            r_err <= r_err + 1'b1;
        end
    end

    assign bus.gate_a    = r_gate_a;
    assign bus.gate_b    = r_gate_b;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.fail_mask = r_fail_mask;
    assign bus.err_count = r_err;
endmodule

// File: tb/tb_gate_selftest_seq.sv
// Directed bench for gate_selftest_seq driving a NAND-built XOR.
module tb_gate_selftest_seq;
    import gate_seq_pkg::*;

    logic clk;
    logic rst_n;

    gate_selftest_seq_if #(.CNT_W(8)) if1 ();
    gate_selftest_seq_if #(.CNT_W(2)) if2 ();

    gate_selftest_seq #(.SETTLE_CYCLES(2), .CNT_W(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );
    nand_gate_xor u_gate1 (.a(if1.gate_a), .b(if1.gate_b), .y(if1.gate_y));

    gate_selftest_seq #(.SETTLE_CYCLES(2), .CNT_W(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );
    nand_gate_xor u_gate2 (.a(if2.gate_a), .b(if2.gate_b), .y(if2.gate_y));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] tt;
        logic [3:0] exp_fm;
        logic       exp_pass;
        int         exp_err;
    } vec_t;

    vec_t tbl [7];
    int   n_vec;
    int   n_miss;
    int   nd;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full sweep on DUT1 with timing checks; optional start/clr_err pokes
    // are held for one cycle beginning at the given edge index.
    task automatic sweep1(input logic [3:0] tt, input int start_poke, input int clr_poke);
        int de;
        de = -1;
        @(negedge clk);
        if1.expect_tt = tt;
        if1.start     = 1'b1;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        for (int e = 0; e <= 40; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            if (e == start_poke)          if1.start   = 1'b1;
            else if (e == start_poke + 1) if1.start   = 1'b0;
            if (e == clr_poke)            if1.clr_err = 1'b1;
            else if (e == clr_poke + 1)   if1.clr_err = 1'b0;
            if ((e % 3) == 0 && e <= 9) chk("gate_vec", {if1.gate_a, if1.gate_b}, e / 3);
            if (e == 0 || e == 12)     chk("busy_in_sweep", if1.busy, 1);
            if (if1.done) begin
                de = e;
                break;
            end
        end
        if1.start   = 1'b0;
        if1.clr_err = 1'b0;
        chk("done_edge", de, 13);
        chk("busy_at_done", if1.busy, 0);
    endtask

    task automatic sweep2(input logic [3:0] tt);
        int seen;
        seen = 0;
        @(negedge clk);
        if2.expect_tt = tt;
        if2.start     = 1'b1;
        @(posedge clk);
        #1;
        if2.start = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick(1);
            if (if2.done) begin
                seen = 1;
                break;
            end
        end
        chk("dut2_done_seen", seen, 1);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        tbl[0] = '{TT_XOR,  4'b0000, 1'b1, 0};
        tbl[1] = '{TT_NAND, 4'b0001, 1'b0, 1};
        tbl[2] = '{TT_NAND, 4'b0001, 1'b0, 2};
        tbl[3] = '{TT_AND,  4'b1110, 1'b0, 5};
        tbl[4] = '{TT_OR,   4'b1000, 1'b0, 6};
        tbl[5] = '{TT_NOR,  4'b0111, 1'b0, 9};
        tbl[6] = '{TT_XNOR, 4'b1111, 1'b0, 13};

        rst_n = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0; if1.clr_err = 1'b0; if1.expect_tt = '0;
        if2.start = 1'b0; if2.abort = 1'b0; if2.clr_err = 1'b0; if2.expect_tt = '0;
        #12;
        chk("rst_gate_a", if1.gate_a, 0);
        chk("rst_gate_b", if1.gate_b, 0);
        chk("rst_busy", if1.busy, 0);
        chk("rst_done", if1.done, 0);
        chk("rst_pass", if1.pass, 0);
        chk("rst_fail_mask", if1.fail_mask, 0);
        chk("rst_err", if1.err_count, 0);
        chk("rst_err2", if2.err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table sweeps; err_count accumulates across entries.
        for (int i = 0; i < 7; i++) begin
            sweep1(tbl[i].tt, -1, -1);
            chk("tbl_fail_mask", if1.fail_mask, tbl[i].exp_fm);
            chk("tbl_pass", if1.pass, tbl[i].exp_pass);
            chk("tbl_err", if1.err_count, tbl[i].exp_err);
        end

        @(negedge clk);
        if1.clr_err = 1'b1;
        tick(1);
        if1.clr_err = 1'b0;
        chk("clr_err", if1.err_count, 0);

        // Abort during SETTLE of vector 2.
        sweep1(TT_XOR, -1, -1);
        chk("pre_abort_pass", if1.pass, 1);
        @(negedge clk);
        if1.expect_tt = TT_NAND;
        if1.start     = 1'b1;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        tick(6);
        chk("abort_vec2", {if1.gate_a, if1.gate_b}, 2);
        @(negedge clk);
        if1.abort = 1'b1;
        tick(1);
        if1.abort = 1'b0;
        chk("abort_busy", if1.busy, 0);
        chk("abort_gate", {if1.gate_a, if1.gate_b}, 0);
        chk("abort_fail_mask", if1.fail_mask, 4'b0001);
        chk("abort_pass", if1.pass, 0);
        chk("abort_err", if1.err_count, 1);
        nd = 0;
        for (int e = 0; e < 20; e++) begin
            tick(1);
            if (if1.done) nd++;
        end
        chk("abort_no_done", nd, 0);
        sweep1(TT_XOR, -1, -1);
        chk("post_abort_pass", if1.pass, 1);
        chk("post_abort_fm", if1.fail_mask, 0);

        // start while busy is ignored; timing checked inside sweep1.
        sweep1(TT_XOR, 5, -1);
        chk("busy_start_pass", if1.pass, 1);

        // start + abort together in IDLE.
        @(negedge clk);
        if1.expect_tt = TT_XNOR;
        if1.start     = 1'b1;
        if1.abort     = 1'b1;
        tick(1);
        if1.start = 1'b0;
        if1.abort = 1'b0;
        chk("start_abort_busy", if1.busy, 0);
        nd = 0;
        for (int e = 0; e < 20; e++) begin
            tick(1);
            if (if1.done || if1.busy) nd++;
        end
        chk("start_abort_idle", nd, 0);
        chk("start_abort_pass", if1.pass, 1);

        // clr_err coincident with the vector-0 mismatch sample.
        sweep1(TT_NAND, -1, 2);
        chk("clr_vs_inc_err", if1.err_count, 0);
        chk("clr_vs_inc_fm", if1.fail_mask, 4'b0001);

        // Narrow saturating counter.
        sweep2(TT_XNOR);
        chk("sat_fm", if2.fail_mask, 4'b1111);
        chk("sat_err1", if2.err_count, 3);
        sweep2(TT_XNOR);
        chk("sat_err2", if2.err_count, 3);

        // Reset mid-SAMPLE of vector 1, off the clock edge.
        @(negedge clk);
        if1.expect_tt = TT_NAND;
        if1.start     = 1'b1;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gate", {if1.gate_a, if1.gate_b}, 0);
        chk("mid_rst_busy", if1.busy, 0);
        chk("mid_rst_done", if1.done, 0);
        chk("mid_rst_pass", if1.pass, 0);
        chk("mid_rst_fm", if1.fail_mask, 0);
        chk("mid_rst_err", if1.err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep1(TT_XOR, -1, -1);
        chk("post_rst_pass", if1.pass, 1);
        chk("post_rst_err", if1.err_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
